// File: rtl/tnoc_route_controller.sv
// tnoc_route_controller: steers a single flit stream onto one of ENTRIES
// output ports through a one-hot demux.
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_valid / o_ready  upstream flit handshake
//   i_head / i_tail    packet framing (both high = single-flit packet)
//   i_destination      one-hot destination, sampled on the head flit only
//   o_select           one-hot demux select (zero when nothing is routed)
//   o_valid / i_ready  per-port downstream handshake
//   o_busy             route locked to a multi-flit packet
//   o_error            one-cycle pulse per dropped packet
module tnoc_route_controller #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_head,
  input  logic               i_tail,
  input  logic [ENTRIES-1:0] i_destination,
  output logic [ENTRIES-1:0] o_select,
  output logic [ENTRIES-1:0] o_valid,
  input  logic [ENTRIES-1:0] i_ready,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] route_q, route_d;
  logic               error_q, error_d;
  logic [ENTRIES-1:0] select_c;
  logic               ready_c;
  logic               dest_legal_c;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign dest_legal_c = (i_destination != '0) &&
                        ((i_destination & (i_destination - ENTRIES'(1))) == '0);

  // Next-state, route latch and combinational steering.
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    error_d  = 1'b0;
    select_c = '0;
    ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_head && dest_legal_c) begin
            select_c = i_destination;
            ready_c  = |(i_ready & i_destination);
            if (ready_c) begin
              route_d = i_destination;
              if (!i_tail) state_d = BUSY;
            end
          end else begin
            // Illegal destination or orphan flit: swallow the whole packet.
            ready_c = 1'b1;
            error_d = 1'b1;
            if (!i_tail) state_d = DROP;
          end
        end
      end
      BUSY: begin
        // Head/destination ignored here: a stray head is forwarded as body.
        select_c = route_q;
        ready_c  = |(i_ready & route_q);
        if (i_valid && ready_c && i_tail) state_d = IDLE;
      end
      DROP: begin
        ready_c = 1'b1;
        if (i_valid && i_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, route and error registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      route_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      error_q <= error_d;
    end
  end

  // Combinational steering is forced quiet while reset is held.
  assign o_select = i_rst ? '0 : select_c;
  assign o_valid  = o_select & {ENTRIES{i_valid}};
  assign o_ready  = ready_c & ~i_rst;
  assign o_busy   = (state_q == BUSY);
  assign o_error  = error_q;

endmodule

// File: tb/tb_tnoc_route_controller.sv
module tb_tnoc_route_controller;

  localparam int unsigned N = 4;

  typedef struct {
    int             cyc;
    logic [N-1:0]   sel;
    logic [N-1:0]   val;
    logic           rdy;
    logic           busy;
    logic           err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, head, tail;
  logic [N-1:0] dest, irdy;
  logic [N-1:0] o_select, o_valid;
  logic         o_ready, o_busy, o_error;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  tnoc_route_controller #(.ENTRIES(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_head(head), .i_tail(tail), .i_destination(dest),
    .o_select(o_select), .o_valid(o_valid), .i_ready(irdy),
    .o_busy(o_busy), .o_error(o_error)
  );

  function automatic logic onehot0(input logic [N-1:0] x);
    return (x & (x - N'(1))) == '0;
  endfunction

  // Monitor: pops one expected record per presented cycle and compares.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp += 5;
      if (o_select !== e.sel) begin n_fail++; $display("FAIL c%0d select got=%b exp=%b", e.cyc, o_select, e.sel); end
      if (o_valid  !== e.val) begin n_fail++; $display("FAIL c%0d valid got=%b exp=%b", e.cyc, o_valid, e.val); end
      if (o_ready  !== e.rdy) begin n_fail++; $display("FAIL c%0d ready got=%b exp=%b", e.cyc, o_ready, e.rdy); end
      if (o_busy   !== e.busy) begin n_fail++; $display("FAIL c%0d busy got=%b exp=%b", e.cyc, o_busy, e.busy); end
      if (o_error  !== e.err) begin n_fail++; $display("FAIL c%0d error got=%b exp=%b", e.cyc, o_error, e.err); end
      n_cmp++;
      if (!(onehot0(o_select) && onehot0(o_valid))) begin
        n_fail++;
        $display("FAIL c%0d onehot sel=%b val=%b exp=zero-or-onehot", e.cyc, o_select, o_valid);
      end
    end
  end

  // Drive one cycle of stimulus and queue its hand-computed response.
  task automatic step(input logic r, input logic v, input logic h, input logic t,
                      input logic [N-1:0] d, input logic [N-1:0] rd,
                      input logic [N-1:0] esel, input logic [N-1:0] eval,
                      input logic erdy, input logic ebusy, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; valid = v; head = h; tail = t; dest = d; irdy = rd;
    e.cyc = cyc; e.sel = esel; e.val = eval; e.rdy = erdy; e.busy = ebusy; e.err = eerr;
    exp_q.push_back(e);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; head = 1'b0; tail = 1'b0; dest = '0; irdy = '0;
    // Reset held with a legal head presented: everything quiet.
    step(1, 1, 1, 0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 1, 1, 1, 4'b0010, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    // 3-flit packet to port 2.
    step(0, 1, 1, 0, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 1, 0, 0);
    step(0, 1, 0, 0, 4'b0000, 4'b1111, 4'b0100, 4'b0100, 1, 1, 0);
    step(0, 1, 0, 1, 4'b0000, 4'b1111, 4'b0100, 4'b0100, 1, 1, 0);
    // Single-flit to port 0, then 2-flit to port 3 with no bubble.
    step(0, 1, 1, 1, 4'b0001, 4'b1111, 4'b0001, 4'b0001, 1, 0, 0);
    step(0, 1, 1, 0, 4'b1000, 4'b1111, 4'b1000, 4'b1000, 1, 0, 0);
    step(0, 1, 0, 1, 4'b0000, 4'b1111, 4'b1000, 4'b1000, 1, 1, 0);
    step(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    // 4-flit to port 1 under back-pressure; destination/head changes ignored.
    step(0, 1, 1, 0, 4'b0010, 4'b1010, 4'b0010, 4'b0010, 1, 0, 0);
    step(0, 1, 0, 0, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 0, 1, 0);
    step(0, 1, 0, 0, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 0, 1, 0);
    step(0, 1, 0, 0, 4'b1000, 4'b1010, 4'b0010, 4'b0010, 1, 1, 0);
    step(0, 1, 1, 0, 4'b0001, 4'b1010, 4'b0010, 4'b0010, 1, 1, 0);
    step(0, 1, 0, 1, 4'b1000, 4'b1010, 4'b0010, 4'b0010, 1, 1, 0);
    // Multi-hot head: packet dropped, one error pulse.
    step(0, 1, 1, 0, 4'b0110, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);
    step(0, 1, 0, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    // Orphan tail in IDLE, then a legal single-flit head.
    step(0, 1, 0, 1, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 1, 1, 1, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 1, 0, 1);
    // Zero destination on a single-flit head.
    step(0, 1, 1, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1);
    // Reset during flit 2 of a 4-flit packet to port 2; remainder dropped.
    step(0, 1, 1, 0, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 1, 0, 0);
    step(1, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    step(0, 1, 0, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);
    step(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tnoc_route_controller.md
Name: tnoc_route_controller

Overview:
- Sequences the flit-level one-hot demultiplexer for a single input stream onto ENTRIES output ports.
- Samples the destination on the head flit and locks the route until the tail flit is accepted.
- Drives the one-hot demux select, gates per-port valids and returns the selected port's ready upstream.
- Discards packets with illegal destinations or missing head flits, flagging each with an error pulse.

Parameters:
- ENTRIES, 8, number of output ports (≥2)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  upstream flit valid
- o_ready  output  1  upstream flit ready
- i_head  input  1  flit is first of packet
- i_tail  input  1  flit is last of packet (head and tail both 1 = single-flit packet)
- i_destination  input  ENTRIES  one-hot destination, meaningful only on head flit
- o_select  output  ENTRIES  one-hot select to demux data path
- o_valid  output  ENTRIES  per-port valid
- i_ready  input  ENTRIES  per-port ready
- o_busy  output  1  route locked (state BUSY)
- o_error  output  1  one-cycle pulse per dropped packet

Behaviour:
- Interface: one clock i_clk; i_rst asynchronous, active-high.
- States: IDLE, BUSY, DROP.
- Reset values: state=IDLE, latched route=0, o_busy=0, o_error=0. While i_rst is high, o_select=0, o_valid=0 and o_ready=0.
- Handshake: a flit transfers when i_valid && o_ready.
- Route legality: i_destination is legal iff exactly one bit is set.
- IDLE, head flit with legal destination:
  - o_select=i_destination (combinational, zero latency).
  - o_valid=i_destination & {ENTRIES{i_valid}}.
  - o_ready=|(i_ready & i_destination).
  - On handshake: latch route. If i_tail=0, go to BUSY. If i_tail=1, stay IDLE.
- IDLE, head flit with illegal destination (0 or multi-hot):
  - o_select=0, o_valid=0, o_ready=1.
  - On handshake: o_error=1 next cycle. If i_tail=0, go to DROP.
- IDLE, i_valid with i_head=0 (orphan flit): treated as an illegal packet, handled as above.
- IDLE, i_valid=0: o_select=0, o_valid=0, o_ready=0.
- BUSY:
  - o_select=latched route; i_head and i_destination are ignored.
  - o_valid=route & {ENTRIES{i_valid}}; o_ready=|(i_ready & route).
  - Tail handshake → IDLE; the next cycle is free to accept a new head.
  - A flit with i_head=1 in BUSY is forwarded as body; no re-route.
- DROP:
  - o_ready=1, o_valid=0, o_select=0.
  - Tail handshake → IDLE. No further o_error within the same packet.
- o_busy=1 exactly when state==BUSY.
- o_error: registered; high for exactly one cycle, the cycle after the offending head/orphan handshake.
- Back-pressure: the selected i_ready=0 holds the flit. The route and state are unchanged. Non-selected ready bits have no effect.
- Throughput: one flit per cycle, with no bubble between back-to-back packets (tail in cycle N, new head in cycle N+1).
- Reset mid-packet: returns to IDLE immediately. The remaining flits of that packet arrive without a head, are treated as orphans and dropped with one o_error.
- Invariant: o_valid and o_select are always zero or one-hot.
- Implementation: state register plus route register of width ENTRIES. Legality check is a popcount==1 (or x&(x-1)==0 with x≠0).

Test Plan:
- ENTRIES=4. Head dest=4'b0100, 3-flit packet, all i_ready=1 → o_select=4'b0100 for 3 consecutive cycles. o_valid[2] high on those cycles, all others 0. o_busy high on cycles 2–3. Back in IDLE after the tail.
- Single-flit packet dest=4'b0001, then immediately 2-flit dest=4'b1000 → o_valid[0] in cycle 0, o_valid[3] in cycles 1–2, no bubble, o_busy stays 0 in cycle 1.
- 4-flit packet to port 1 with i_ready[1] toggling 1,0,0,1,… and i_ready[3]=1 constant → o_ready mirrors i_ready[1]. All 4 flits transfer in 6 cycles. Changing i_destination mid-packet to 4'b1000 has no effect.
- Head dest=4'b0110 (multi-hot), 3 flits → o_ready=1 for 3 cycles, o_valid=0. o_error high for exactly one cycle, the cycle after the head. State returns to IDLE.
- Body flit (i_head=0, i_tail=1) in IDLE → consumed with o_ready=1, o_valid=0, one o_error pulse. A following legal head is routed normally.
- Assert i_rst during flit 2 of a 4-flit packet to port 2 → o_valid/o_select=0 during reset. After release, flits 3–4 are dropped with one o_error and o_busy=0.
